// File: rtl/ex_mem_register_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: default widths,
// memory access size codes, bubble field values and the per-edge action.
package ex_mem_register_pkg;

  localparam int DEFAULT_DATA_BUS_WIDTH      = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH      = 5;
  localparam int DEFAULT_MEM_WIDTH_BUS_WIDTH = 2;

  localparam logic [1:0] CODE_MEM_BYTE = 2'b00;
  localparam logic [1:0] CODE_MEM_HALF = 2'b01;
  localparam logic [1:0] CODE_MEM_WORD = 2'b10;

  // A bubble is an all-zero slot: no side effects, byte width, unsigned.
  localparam logic       BUBBLE_CTRL_BIT  = 1'b0;
  localparam logic [1:0] BUBBLE_MEM_WIDTH = 2'b00;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'b00,
    ACT_LOAD  = 2'b01,
    ACT_CLEAR = 2'b10
  } stage_action_e;

endpackage

// File: rtl/ex_mem_register_pipeline_field_reg.sv
// Parameterised stage-boundary latch: async reset, clear beats load, else hold.
module pipeline_field_reg #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Field storage; reset and bubble share the same value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= CLEAR_VALUE;
    end else if (clear) begin
      q <= CLEAR_VALUE;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall, flush, debug enable and halt-drain tracking.
module ex_mem_register
  import ex_mem_register_pkg::*;
#(
  parameter int DATA_BUS_WIDTH      = DEFAULT_DATA_BUS_WIDTH,
  parameter int REG_ADDR_WIDTH      = DEFAULT_REG_ADDR_WIDTH,
  parameter int MEM_WIDTH_BUS_WIDTH = DEFAULT_MEM_WIDTH_BUS_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic                           i_valid,
  input  logic [DATA_BUS_WIDTH-1:0]      i_alu_result,
  input  logic [DATA_BUS_WIDTH-1:0]      i_store_data,
  input  logic [REG_ADDR_WIDTH-1:0]      i_wb_reg_addr,
  input  logic                           i_reg_wr,
  input  logic                           i_mem_rd,
  input  logic                           i_mem_wr,
  input  logic                           i_mem_to_reg,
  input  logic [MEM_WIDTH_BUS_WIDTH-1:0] i_mem_width,
  input  logic                           i_mem_signed,
  input  logic                           i_halt,
  output logic                           o_valid,
  output logic [DATA_BUS_WIDTH-1:0]      o_alu_result,
  output logic [DATA_BUS_WIDTH-1:0]      o_store_data,
  output logic [REG_ADDR_WIDTH-1:0]      o_wb_reg_addr,
  output logic                           o_reg_wr,
  output logic                           o_mem_rd,
  output logic                           o_mem_wr,
  output logic                           o_mem_to_reg,
  output logic [MEM_WIDTH_BUS_WIDTH-1:0] o_mem_width,
  output logic                           o_mem_signed,
  output logic                           o_halt,
  output logic                           o_drained
);

  localparam int DATA_W = 2 * DATA_BUS_WIDTH;
  localparam int CTRL_W = 7 + MEM_WIDTH_BUS_WIDTH;

  localparam logic [DATA_W-1:0]         DATA_BUBBLE = {DATA_W{1'b0}};
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_BUBBLE = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [CTRL_W-1:0]         CTRL_BUBBLE = {
    {7{BUBBLE_CTRL_BIT}}, {(MEM_WIDTH_BUS_WIDTH / 2){BUBBLE_MEM_WIDTH}}
  };

  stage_action_e                 action_s;
  logic                          load_s;
  logic                          clear_s;
  logic                          drain_set_s;
  logic                          drained_r;
  logic [DATA_W-1:0]             data_d_s;
  logic [DATA_W-1:0]             data_q_s;
  logic [CTRL_W-1:0]             ctrl_d_s;
  logic [CTRL_W-1:0]             ctrl_q_s;

  // Per-edge priority: enable freeze, drained freeze, flush, stall, then load or bubble
  always_comb begin
    action_s = ACT_HOLD;
    if (!i_enable) begin
      action_s = ACT_HOLD;
    end else if (drained_r) begin
      action_s = ACT_HOLD;
    end else if (i_flush) begin
      action_s = ACT_CLEAR;
    end else if (i_stall) begin
      action_s = ACT_HOLD;
    end else if (!i_valid) begin
      action_s = ACT_CLEAR;
    end else begin
      action_s = ACT_LOAD;
    end
  end

  // Fan the resolved action out as load/clear strobes for every field group
  always_comb begin
    load_s  = 1'b0;
    clear_s = 1'b0;
    case (action_s)
      ACT_LOAD:  load_s  = 1'b1;
      ACT_CLEAR: clear_s = 1'b1;
      ACT_HOLD:  load_s  = 1'b0;
      default: begin
        load_s  = 1'b0;
        clear_s = 1'b0;
      end
    endcase
  end

  assign drain_set_s = load_s & i_halt;
  assign data_d_s    = {i_alu_result, i_store_data};
  assign ctrl_d_s    = {i_valid, i_reg_wr, i_mem_rd, i_mem_wr, i_mem_to_reg,
                        i_mem_signed, i_halt, i_mem_width};

  pipeline_field_reg #(.WIDTH(DATA_W), .CLEAR_VALUE(DATA_BUBBLE)) u_data_reg (
    .clk(i_clk), .rst(i_reset), .load(load_s), .clear(clear_s),
    .d(data_d_s), .q(data_q_s)
  );

  pipeline_field_reg #(.WIDTH(CTRL_W), .CLEAR_VALUE(CTRL_BUBBLE)) u_ctrl_reg (
    .clk(i_clk), .rst(i_reset), .load(load_s), .clear(clear_s),
    .d(ctrl_d_s), .q(ctrl_q_s)
  );

  pipeline_field_reg #(.WIDTH(REG_ADDR_WIDTH), .CLEAR_VALUE(ADDR_BUBBLE)) u_addr_reg (
    .clk(i_clk), .rst(i_reset), .load(load_s), .clear(clear_s),
    .d(i_wb_reg_addr), .q(o_wb_reg_addr)
  );

  // Sticky drain flag: set alongside the halt capture, only reset clears it
  pipeline_field_reg #(.WIDTH(1), .CLEAR_VALUE(1'b0)) u_drain_reg (
    .clk(i_clk), .rst(i_reset), .load(drain_set_s), .clear(1'b0),
    .d(1'b1), .q(drained_r)
  );

  assign {o_alu_result, o_store_data} = data_q_s;
  assign {o_valid, o_reg_wr, o_mem_rd, o_mem_wr, o_mem_to_reg,
          o_mem_signed, o_halt, o_mem_width} = ctrl_q_s;
  assign o_drained = drained_r;

endmodule

// File: tb/tb_ex_mem_register.sv
// Self-checking bench for ex_mem_register: spec-level model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_ex_mem_register;
  import ex_mem_register_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, stall, flush, valid;
  logic [31:0] alu, store;
  logic [4:0]  wb;
  logic        reg_wr, mem_rd, mem_wr, m2r, msigned, halt;
  logic [1:0]  mwidth;

  logic        o_valid, o_reg_wr, o_mem_rd, o_mem_wr, o_mem_to_reg;
  logic        o_mem_signed, o_halt, o_drained;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_wb_reg_addr;
  logic [1:0]  o_mem_width;

  int checks = 0;
  int errors = 0;

  ex_mem_register dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_alu_result(alu), .i_store_data(store), .i_wb_reg_addr(wb),
    .i_reg_wr(reg_wr), .i_mem_rd(mem_rd), .i_mem_wr(mem_wr), .i_mem_to_reg(m2r),
    .i_mem_width(mwidth), .i_mem_signed(msigned), .i_halt(halt),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_wb_reg_addr(o_wb_reg_addr), .o_reg_wr(o_reg_wr), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_mem_to_reg(o_mem_to_reg), .o_mem_width(o_mem_width),
    .o_mem_signed(o_mem_signed), .o_halt(o_halt), .o_drained(o_drained)
  );

  always #5 clk = ~clk;

  // Model: one record per slot; the output slot is replaced, blanked or kept.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  wb;
    logic        reg_wr, mem_rd, mem_wr, m2r;
    logic [1:0]  width;
    logic        signd, halt;
  } slot_t;

  slot_t m_slot;
  logic  m_drained;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slot    = '0;
      m_drained = 1'b0;
    end else if (en && !m_drained) begin
      if (flush || (!stall && !valid)) begin
        m_slot = '0;
      end else if (!stall) begin
        m_slot = '{valid, alu, store, wb, reg_wr, mem_rd, mem_wr, m2r, mwidth, msigned, halt};
        m_drained = halt;
      end
    end
  end

  slot_t dut_slot;
  assign dut_slot = '{o_valid, o_alu_result, o_store_data, o_wb_reg_addr, o_reg_wr,
                      o_mem_rd, o_mem_wr, o_mem_to_reg, o_mem_width, o_mem_signed, o_halt};

  // Whole-output comparison against the model on every falling edge
  always @(negedge clk) begin
    checks++;
    if (dut_slot !== m_slot || o_drained !== m_drained) begin
      errors++;
      $display("FAIL model_cmp t=%0t dut=%h drained=%b expected=%h drained=%b",
               $time, dut_slot, o_drained, m_slot, m_drained);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b0;
    alu = 32'h0; store = 32'h0; wb = 5'd0;
    reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; m2r = 1'b0;
    mwidth = CODE_MEM_BYTE; msigned = 1'b0; halt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_alu", o_alu_result, 32'h0);
    chk("reset_width", {30'd0, o_mem_width}, 32'd0);
    chk("reset_drained", {31'd0, o_drained}, 32'd0);
    rst = 1'b0;

    // Normal store
    valid = 1'b1; alu = 32'h0000_1004; store = 32'hDEAD_BEEF; mem_wr = 1'b1;
    mwidth = CODE_MEM_WORD; wb = 5'd3;
    step();
    chk("norm_valid", {31'd0, o_valid}, 32'd1);
    chk("norm_alu", o_alu_result, 32'h0000_1004);
    chk("norm_store", o_store_data, 32'hDEAD_BEEF);
    chk("norm_mem_wr", {31'd0, o_mem_wr}, 32'd1);
    chk("norm_width", {30'd0, o_mem_width}, 32'd2);

    // Stall three cycles with changing inputs, then stall+flush
    idle_inputs();
    valid = 1'b1; alu = 32'h10; reg_wr = 1'b1; wb = 5'd7; mwidth = CODE_MEM_HALF;
    step();
    chk("stall_load", o_alu_result, 32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu = 32'h100 + i; wb = 5'd9;
      step();
      chk("stall_hold_alu", o_alu_result, 32'h10);
      chk("stall_hold_wb", {27'd0, o_wb_reg_addr}, 32'd7);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_reg_wr", {31'd0, o_reg_wr}, 32'd0);
    chk("flush_alu", o_alu_result, 32'h0);

    // Enable freeze ignores flush and new inputs
    idle_inputs();
    valid = 1'b1; alu = 32'h20; reg_wr = 1'b1;
    step();
    en = 1'b0; flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu = 32'h200 + i;
      step();
      chk("freeze_alu", o_alu_result, 32'h20);
      chk("freeze_valid", {31'd0, o_valid}, 32'd1);
    end
    en = 1'b1; flush = 1'b0; alu = 32'h30;
    step();
    chk("reenable_alu", o_alu_result, 32'h30);

    // Illegal combination captured verbatim
    mem_rd = 1'b1; mem_wr = 1'b1; mwidth = 2'b11; msigned = 1'b1; m2r = 1'b1;
    step();
    chk("illegal_rdwr", {30'd0, o_mem_rd, o_mem_wr}, 32'd3);
    chk("illegal_width", {30'd0, o_mem_width}, 32'd3);

    // Invalid slot carrying side effects becomes a bubble
    idle_inputs();
    valid = 1'b0; reg_wr = 1'b1; mem_rd = 1'b1; halt = 1'b1; alu = 32'h77;
    step();
    chk("inv_side_fx", {28'd0, o_valid, o_reg_wr, o_mem_rd, o_halt}, 32'd0);
    chk("inv_drained", {31'd0, o_drained}, 32'd0);
    chk("inv_alu", o_alu_result, 32'h0);

    // Asynchronous reset between edges
    idle_inputs();
    valid = 1'b1; alu = 32'h44; reg_wr = 1'b1;
    step();
    chk("pre_rst_alu", o_alu_result, 32'h44);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_alu", o_alu_result, 32'h0);
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_drained", {31'd0, o_drained}, 32'd0);
    step();
    rst = 1'b0;

    // Halt drain: later loads and flushes ignored until reset
    idle_inputs();
    valid = 1'b1; halt = 1'b1; alu = 32'h60;
    step();
    chk("halt_o_halt", {31'd0, o_halt}, 32'd1);
    chk("halt_drained", {31'd0, o_drained}, 32'd1);
    halt = 1'b0; alu = 32'h55;
    step(); step();
    chk("drained_hold_alu", o_alu_result, 32'h60);
    flush = 1'b1;
    step();
    chk("drained_flush_ign", o_alu_result, 32'h60);
    chk("drained_sticky", {31'd0, o_drained}, 32'd1);
    rst = 1'b1;
    #1;
    chk("drain_rst", {31'd0, o_drained}, 32'd0);
    step();
    rst = 1'b0;
    flush = 1'b0;
    step();
    chk("post_rst_load", o_alu_result, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
